// File: rtl/riscv_ctrl_pkg.sv
// riscv_ctrl_pkg
// Shared constants for the RV32 subset (R-type, lw, sw, beq) multicycle
// controller, ALU control and datapath: major opcodes, controller state
// encodings and the ALU operand/operation select codes.
// No ports (package).
package riscv_ctrl_pkg;

    // Major opcodes, IR[6:0]
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // ALU operation requests handed to ALU control
    localparam logic [1:0] ALU_OP_ADD   = 2'b00;
    localparam logic [1:0] ALU_OP_SUB   = 2'b01;
    localparam logic [1:0] ALU_OP_FUNCT = 2'b10;

    // ALU operand B selects
    localparam logic [1:0] ALUB_RS2  = 2'b00;
    localparam logic [1:0] ALUB_FOUR = 2'b01;
    localparam logic [1:0] ALUB_IMM  = 2'b10;

    // Controller states; the encoding is visible on the debug port
    typedef enum logic [3:0] {
        ST_FETCH    = 4'd0,
        ST_DECODE   = 4'd1,
        ST_EXEC_R   = 4'd2,
        ST_WB_R     = 4'd3,
        ST_MEM_ADDR = 4'd4,
        ST_MEM_RD   = 4'd5,
        ST_WB_MEM   = 4'd6,
        ST_MEM_WR   = 4'd7,
        ST_BRANCH   = 4'd8,
        ST_ERROR    = 4'd9
    } ctrlState_t;

    // States that hold a memory request open
    function automatic logic isMemState(input ctrlState_t s);
        return (s == ST_FETCH) || (s == ST_MEM_RD) || (s == ST_MEM_WR);
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// mem_wait_timer
// Counts cycles a memory request has been waiting for ready and flags the
// cycle on which the wait budget runs out.
// Ports:
//   clk      in   clock, rising edge
//   rst_n    in   async reset, active-low
//   clear    in   restart the count (no request open, or request completing)
//   enable   in   request open and memory not ready this cycle
//   timeout  out  this is the WAIT_MAX-th consecutive unanswered cycle
module mem_wait_timer #(
    parameter int WAIT_MAX = 15
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic timeout
);

    localparam int CW = $clog2(WAIT_MAX + 1);

    logic [CW-1:0] waitCount;

    // The count holds the number of unanswered cycles already spent, so the
    // current cycle is the last one allowed when it equals WAIT_MAX-1.
    assign timeout = enable && (waitCount == CW'(WAIT_MAX - 1));

    // Clear has priority; the controller never asserts both at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCount <= '0;
        end else if (clear) begin
            waitCount <= '0;
        end else if (enable) begin
            waitCount <= waitCount + CW'(1);
        end
    end

endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
// Moore sequencer for the multicycle RV32 subset datapath (R-type, lw, sw,
// beq) sharing one ALU and one memory port. Steps each instruction through
// fetch/decode/execute/memory/write-back, drives the datapath selects and
// the memory request, and parks in a sticky ERROR state on an unsupported
// opcode or a memory wait that exceeds WAIT_MAX cycles.
// Ports:
//   clk, rst_n            clock (rising) and async active-low reset
//   opcode                IR[6:0], looked at only in DECODE and MEM_ADDR
//   mem_ready             memory completes the open request this cycle
//   pc_write, branch      unconditional / zero-qualified PC load
//   pc_src                0 = ALU result, 1 = ALUOut
//   ir_write              load IR from memory read data
//   i_or_d                memory address 0 = PC, 1 = ALUOut
//   mem_req, mem_we       memory request and its write qualifier
//   mem_to_reg, reg_write register write data select and enable
//   alu_src_a, alu_src_b  ALU operand selects
//   alu_op                ALU operation request
//   illegal, timeout_err  sticky error flags
//   state_o               current state encoding (debug)
//   retired               completed instruction count, wraps
module multicycle_ctrl_fsm
    import riscv_ctrl_pkg::*;
#(
    parameter int WAIT_MAX = 15,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [6:0]       opcode,
    input  logic             mem_ready,
    output logic             pc_write,
    output logic             branch,
    output logic             pc_src,
    output logic             ir_write,
    output logic             i_or_d,
    output logic             mem_req,
    output logic             mem_we,
    output logic             mem_to_reg,
    output logic             reg_write,
    output logic             alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic             illegal,
    output logic             timeout_err,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] retired
);

    ctrlState_t state;
    logic       memPhase;
    logic       timerClear;
    logic       timerEnable;
    logic       memTimeout;

    assign memPhase    = isMemState(state);
    assign timerEnable = memPhase & ~mem_ready;
    assign timerClear  = ~memPhase | mem_ready;
    assign state_o     = state;

    mem_wait_timer #(
        .WAIT_MAX (WAIT_MAX)
    ) uWaitTimer (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (timerClear),
        .enable  (timerEnable),
        .timeout (memTimeout)
    );

    // Datapath controls decoded from the state register. Reset itself lands
    // in FETCH, so the memory request and the fetch-completion strobes are
    // qualified by rst_n: an access aborted by reset drops its request at
    // once and no IR or PC update can slip out while reset is held.
    always_comb begin
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_src     = 1'b0;
        ir_write   = 1'b0;
        i_or_d     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        mem_to_reg = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = ALUB_RS2;
        alu_op     = ALU_OP_ADD;
        case (state)
            ST_FETCH: begin
                mem_req   = rst_n;
                alu_src_b = ALUB_FOUR;
                ir_write  = rst_n & mem_ready;
                pc_write  = rst_n & mem_ready;
            end
            ST_DECODE: begin
                alu_src_b = ALUB_IMM;
            end
            ST_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_FUNCT;
            end
            ST_WB_R: begin
                reg_write = 1'b1;
            end
            ST_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = ALUB_IMM;
            end
            ST_MEM_RD: begin
                mem_req = rst_n;
                i_or_d  = 1'b1;
            end
            ST_WB_MEM: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            ST_MEM_WR: begin
                mem_req = rst_n;
                mem_we  = rst_n;
                i_or_d  = 1'b1;
            end
            ST_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = ALU_OP_SUB;
                branch    = 1'b1;
                pc_src    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // State sequencing, retired-instruction count and sticky error flags.
    // A memory state leaves on mem_ready even in the cycle the wait budget
    // expires; only an unanswered final cycle diverts to ERROR.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_FETCH;
            retired     <= '0;
            illegal     <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            case (state)
                ST_FETCH: begin
                    if (mem_ready) begin
                        state <= ST_DECODE;
                    end else if (memTimeout) begin
                        state       <= ST_ERROR;
                        timeout_err <= 1'b1;
                    end
                end
                ST_DECODE: begin
                    if (opcode == OP_R) begin
                        state <= ST_EXEC_R;
                    end else if ((opcode == OP_LW) || (opcode == OP_SW)) begin
                        state <= ST_MEM_ADDR;
                    end else if (opcode == OP_BEQ) begin
                        state <= ST_BRANCH;
                    end else begin
                        state   <= ST_ERROR;
                        illegal <= 1'b1;
                    end
                end
                ST_EXEC_R: begin
                    state <= ST_WB_R;
                end
                ST_WB_R: begin
                    state   <= ST_FETCH;
                    retired <= retired + CNT_W'(1);
                end
                // Opcode is looked at again here; anything other than a load
                // or store at this point is treated as illegal.
                ST_MEM_ADDR: begin
                    if (opcode == OP_LW) begin
                        state <= ST_MEM_RD;
                    end else if (opcode == OP_SW) begin
                        state <= ST_MEM_WR;
                    end else begin
                        state   <= ST_ERROR;
                        illegal <= 1'b1;
                    end
                end
                ST_MEM_RD: begin
                    if (mem_ready) begin
                        state <= ST_WB_MEM;
                    end else if (memTimeout) begin
                        state       <= ST_ERROR;
                        timeout_err <= 1'b1;
                    end
                end
                ST_WB_MEM: begin
                    state   <= ST_FETCH;
                    retired <= retired + CNT_W'(1);
                end
                ST_MEM_WR: begin
                    if (mem_ready) begin
                        state   <= ST_FETCH;
                        retired <= retired + CNT_W'(1);
                    end else if (memTimeout) begin
                        state       <= ST_ERROR;
                        timeout_err <= 1'b1;
                    end
                end
                ST_BRANCH: begin
                    state   <= ST_FETCH;
                    retired <= retired + CNT_W'(1);
                end
                ST_ERROR: begin
                    state <= ST_ERROR;
                end
                default: begin
                    state <= ST_ERROR;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb_multicycle_ctrl_fsm
// Directed bench for multicycle_ctrl_fsm with WAIT_MAX=4. Inputs change just
// after the falling edge; outputs are checked 1 ns later, well clear of the
// rising edge.
module tb_multicycle_ctrl_fsm;
    import riscv_ctrl_pkg::*;

    localparam logic [6:0] OPC_R    = 7'b0110011;
    localparam logic [6:0] OPC_LW   = 7'b0000011;
    localparam logic [6:0] OPC_SW   = 7'b0100011;
    localparam logic [6:0] OPC_BEQ  = 7'b1100011;
    localparam logic [6:0] OPC_ADDI = 7'b0010011;

    logic        clk;
    logic        rst_n;
    logic [6:0]  opcode;
    logic        mem_ready;
    logic        pc_write;
    logic        branch;
    logic        pc_src;
    logic        ir_write;
    logic        i_or_d;
    logic        mem_req;
    logic        mem_we;
    logic        mem_to_reg;
    logic        reg_write;
    logic        alu_src_a;
    logic [1:0]  alu_src_b;
    logic [1:0]  alu_op;
    logic        illegal;
    logic        timeout_err;
    logic [3:0]  state_o;
    logic [31:0] retired;

    int total = 0;
    int bad   = 0;

    multicycle_ctrl_fsm #(
        .WAIT_MAX (4),
        .CNT_W    (32)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .opcode      (opcode),
        .mem_ready   (mem_ready),
        .pc_write    (pc_write),
        .branch      (branch),
        .pc_src      (pc_src),
        .ir_write    (ir_write),
        .i_or_d      (i_or_d),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_to_reg  (mem_to_reg),
        .reg_write   (reg_write),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .alu_op      (alu_op),
        .illegal     (illegal),
        .timeout_err (timeout_err),
        .state_o     (state_o),
        .retired     (retired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Watchdog so a broken design can never hang the run
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] op, input logic rdy);
        opcode    = op;
        mem_ready = rdy;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    logic activity;
    logic leftError;

    initial begin
        rst_n = 1'b0;
        applyStimulus(7'd0, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        checkOutput("rst state", 32'(state_o), 32'(ST_FETCH));
        checkOutput("rst retired", retired, 0);
        checkOutput("rst illegal", 32'(illegal), 0);
        checkOutput("rst timeout", 32'(timeout_err), 0);
        checkOutput("rst mem_req", 32'(mem_req), 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 1: R-type, memory always ready; opcode scrambled after DECODE
        applyStimulus(OPC_R, 1'b1);
        checkOutput("r fetch state", 32'(state_o), 32'(ST_FETCH));
        checkOutput("r fetch mem_req", 32'(mem_req), 1);
        checkOutput("r fetch ir_write", 32'(ir_write), 1);
        checkOutput("r fetch pc_write", 32'(pc_write), 1);
        checkOutput("r fetch alub", 32'(alu_src_b), 1);
        checkOutput("r fetch i_or_d", 32'(i_or_d), 0);
        tick();
        applyStimulus(OPC_R, 1'b1);
        checkOutput("r decode state", 32'(state_o), 32'(ST_DECODE));
        checkOutput("r decode alub", 32'(alu_src_b), 2);
        checkOutput("r decode mem_req", 32'(mem_req), 0);
        checkOutput("r decode ir_write", 32'(ir_write), 0);
        tick();
        applyStimulus(OPC_ADDI, 1'b1);
        checkOutput("r exec state", 32'(state_o), 32'(ST_EXEC_R));
        checkOutput("r exec aluop", 32'(alu_op), 2);
        checkOutput("r exec alua", 32'(alu_src_a), 1);
        checkOutput("r exec alub", 32'(alu_src_b), 0);
        checkOutput("r exec reg_write", 32'(reg_write), 0);
        tick();
        applyStimulus(OPC_ADDI, 1'b1);
        checkOutput("r wb state", 32'(state_o), 32'(ST_WB_R));
        checkOutput("r wb reg_write", 32'(reg_write), 1);
        checkOutput("r wb mem_to_reg", 32'(mem_to_reg), 0);
        tick();
        applyStimulus(OPC_LW, 1'b0);
        checkOutput("r done state", 32'(state_o), 32'(ST_FETCH));
        checkOutput("r done retired", retired, 1);
        checkOutput("r done reg_write", 32'(reg_write), 0);

        // 2: lw with two wait cycles on each access
        checkOutput("lw f1 mem_req", 32'(mem_req), 1);
        checkOutput("lw f1 ir_write", 32'(ir_write), 0);
        tick();
        applyStimulus(OPC_LW, 1'b0);
        checkOutput("lw f2 state", 32'(state_o), 32'(ST_FETCH));
        checkOutput("lw f2 mem_req", 32'(mem_req), 1);
        tick();
        applyStimulus(OPC_LW, 1'b1);
        checkOutput("lw f3 ir_write", 32'(ir_write), 1);
        tick();
        applyStimulus(OPC_LW, 1'b0);
        checkOutput("lw decode state", 32'(state_o), 32'(ST_DECODE));
        tick();
        applyStimulus(OPC_LW, 1'b0);
        checkOutput("lw addr state", 32'(state_o), 32'(ST_MEM_ADDR));
        checkOutput("lw addr alub", 32'(alu_src_b), 2);
        checkOutput("lw addr alua", 32'(alu_src_a), 1);
        tick();
        applyStimulus(OPC_LW, 1'b0);
        checkOutput("lw rd1 state", 32'(state_o), 32'(ST_MEM_RD));
        checkOutput("lw rd1 mem_req", 32'(mem_req), 1);
        checkOutput("lw rd1 i_or_d", 32'(i_or_d), 1);
        checkOutput("lw rd1 mem_we", 32'(mem_we), 0);
        tick();
        applyStimulus(OPC_LW, 1'b0);
        checkOutput("lw rd2 state", 32'(state_o), 32'(ST_MEM_RD));
        checkOutput("lw rd2 mem_req", 32'(mem_req), 1);
        tick();
        applyStimulus(OPC_LW, 1'b1);
        checkOutput("lw rd3 mem_req", 32'(mem_req), 1);
        tick();
        applyStimulus(OPC_LW, 1'b0);
        checkOutput("lw wb state", 32'(state_o), 32'(ST_WB_MEM));
        checkOutput("lw wb reg_write", 32'(reg_write), 1);
        checkOutput("lw wb mem_to_reg", 32'(mem_to_reg), 1);
        tick();
        applyStimulus(OPC_SW, 1'b1);
        checkOutput("lw done state", 32'(state_o), 32'(ST_FETCH));
        checkOutput("lw done retired", retired, 2);

        // 3: sw then beq
        tick();
        applyStimulus(OPC_SW, 1'b1);
        tick();
        applyStimulus(OPC_SW, 1'b1);
        checkOutput("sw addr mem_we", 32'(mem_we), 0);
        tick();
        applyStimulus(OPC_SW, 1'b1);
        checkOutput("sw wr state", 32'(state_o), 32'(ST_MEM_WR));
        checkOutput("sw wr mem_we", 32'(mem_we), 1);
        checkOutput("sw wr mem_req", 32'(mem_req), 1);
        checkOutput("sw wr i_or_d", 32'(i_or_d), 1);
        tick();
        applyStimulus(OPC_BEQ, 1'b1);
        checkOutput("sw done mem_we", 32'(mem_we), 0);
        checkOutput("sw done retired", retired, 3);
        tick();
        applyStimulus(OPC_BEQ, 1'b1);
        checkOutput("beq decode branch", 32'(branch), 0);
        tick();
        applyStimulus(OPC_BEQ, 1'b1);
        checkOutput("beq state", 32'(state_o), 32'(ST_BRANCH));
        checkOutput("beq branch", 32'(branch), 1);
        checkOutput("beq pc_src", 32'(pc_src), 1);
        checkOutput("beq aluop", 32'(alu_op), 1);
        checkOutput("beq alua", 32'(alu_src_a), 1);
        checkOutput("beq pc_write", 32'(pc_write), 0);
        tick();
        applyStimulus(OPC_ADDI, 1'b1);
        checkOutput("beq done branch", 32'(branch), 0);
        checkOutput("beq done state", 32'(state_o), 32'(ST_FETCH));
        checkOutput("beq done retired", retired, 4);

        // 4: illegal opcode parks the controller
        tick();
        applyStimulus(OPC_ADDI, 1'b1);
        checkOutput("ill decode illegal", 32'(illegal), 0);
        tick();
        applyStimulus(OPC_R, 1'b1);
        checkOutput("ill state", 32'(state_o), 32'(ST_ERROR));
        checkOutput("ill flag", 32'(illegal), 1);
        activity  = 1'b0;
        leftError = 1'b0;
        for (int i = 0; i < 20; i++) begin
            applyStimulus(OPC_R, i[0]);
            activity = activity | mem_req | mem_we | reg_write | pc_write | ir_write | branch;
            if (state_o != 4'(ST_ERROR)) leftError = 1'b1;
            tick();
        end
        checkOutput("ill idle enables", 32'(activity), 0);
        checkOutput("ill stays", 32'(leftError), 0);
        checkOutput("ill retired", retired, 4);
        rst_n = 1'b0;
        #1;
        checkOutput("ill rst state", 32'(state_o), 32'(ST_FETCH));
        checkOutput("ill rst flag", 32'(illegal), 0);
        checkOutput("ill rst retired", retired, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // 5: fetch wait budget of 4 cycles
        for (int i = 0; i < 4; i++) begin
            applyStimulus(OPC_R, 1'b0);
            checkOutput("to wait state", 32'(state_o), 32'(ST_FETCH));
            tick();
        end
        applyStimulus(OPC_R, 1'b0);
        checkOutput("to state", 32'(state_o), 32'(ST_ERROR));
        checkOutput("to flag", 32'(timeout_err), 1);
        checkOutput("to illegal", 32'(illegal), 0);
        checkOutput("to mem_req", 32'(mem_req), 0);
        rst_n = 1'b0;
        #1;
        checkOutput("to rst flag", 32'(timeout_err), 0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(OPC_SW, 1'b0);
            tick();
        end
        applyStimulus(OPC_SW, 1'b1);
        checkOutput("late ready ir_write", 32'(ir_write), 1);
        tick();
        applyStimulus(OPC_SW, 1'b0);
        checkOutput("late ready state", 32'(state_o), 32'(ST_DECODE));
        checkOutput("late ready flag", 32'(timeout_err), 0);

        // 6: reset in the middle of a store
        tick();
        applyStimulus(OPC_SW, 1'b0);
        tick();
        applyStimulus(OPC_SW, 1'b0);
        checkOutput("abort wr mem_we", 32'(mem_we), 1);
        tick();
        applyStimulus(OPC_SW, 1'b0);
        checkOutput("abort wr state", 32'(state_o), 32'(ST_MEM_WR));
        rst_n = 1'b0;
        #1;
        checkOutput("abort mem_req", 32'(mem_req), 0);
        checkOutput("abort mem_we", 32'(mem_we), 0);
        checkOutput("abort retired", retired, 0);
        checkOutput("abort state", 32'(state_o), 32'(ST_FETCH));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(OPC_R, 1'b1);
            tick();
        end
        applyStimulus(OPC_R, 1'b0);
        checkOutput("post abort state", 32'(state_o), 32'(ST_FETCH));
        checkOutput("post abort retired", retired, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
